// File: rtl/board_game_engine_if.sv
// Game engine bus: buttons, mode/new-game controls,
// renderer read port and status outputs.
interface board_game_engine_if #(
  parameter int N = 3
);
  logic [N*N-1:0] btn;
  logic           vs_cpu;
  logic           new_game;
  logic [2:0]     rd_row;
  logic [2:0]     rd_col;
  logic [1:0]     rd_cell;
  logic [2:0]     game_state;
  logic           turn;
  logic [6:0]     move_count;

  modport master (
    output btn, vs_cpu, new_game,
    output rd_row, rd_col,
    input  rd_cell, game_state,
    input  turn, move_count
  );

  modport slave (
    input  btn, vs_cpu, new_game,
    input  rd_row, rd_col,
    output rd_cell, game_state,
    output turn, move_count
  );
endinterface

// File: rtl/board_game_engine.sv
// N x N, K-in-a-row engine: button capture, CPU seek,
// sequential line walk from the last move.
module board_game_engine #(
  parameter int N = 3,
  parameter int K = 3
) (
  input logic          CLK,
  input logic          RST,
  board_game_engine_if.slave bus
);
  localparam int NC = N * N;
  localparam int IW = $clog2(NC);

  typedef enum logic [2:0] {
    S_INIT, S_PLAY, S_CHECK, S_SEEK,
    S_WIN0, S_WIN1, S_DRAW
  } state_t;

  state_t          r_state;
  logic [1:0]      r_board [NC];
  logic [NC-1:0]   r_s1, r_s2, r_s3;
  logic [IW-1:0]   r_rand, r_probe;
  logic            r_mode, r_turn, r_side;
  logic [6:0]      r_mc;
  logic [2:0]      r_gs;
  logic [2:0]      r_lr, r_lc, r_pr, r_pc;
  logic [1:0]      r_dir;
  logic [3:0]      r_step, r_run;

  logic [NC-1:0]   w_press;
  logic            w_any;
  logic [IW-1:0]   w_sel, w_nidx, w_rd_idx;
  logic [2:0]      w_sel_r, w_sel_c;
  logic [2:0]      w_prb_r, w_prb_c;
  logic [1:0]      w_mark;
  logic            w_inb, w_match;
  int              w_dr, w_dc, w_nr, w_nc;

  assign w_press = r_s3 & ~r_s2;
  assign w_sel_r = 3'(int'(w_sel) / N);
  assign w_sel_c = 3'(int'(w_sel) % N);
  assign w_prb_r = 3'(int'(r_probe) / N);
  assign w_prb_c = 3'(int'(r_probe) % N);
  assign w_mark  = r_turn ? 2'b10 : 2'b01;

  // Descending scan so the lowest pressed index wins
  always_comb begin
    w_any = 1'b0;
    w_sel = '0;
    for (int i = NC - 1; i >= 0; i--) begin
      if (w_press[i]) begin
        w_any = 1'b1;
        w_sel = IW'(i);
      end
    end
  end

  always_comb begin
    w_dr = 0;
    w_dc = 0;
    unique case (r_dir)
      2'd0:    begin w_dr = 0; w_dc = 1;  end
      2'd1:    begin w_dr = 1; w_dc = 0;  end
      2'd2:    begin w_dr = 1; w_dc = 1;  end
      default: begin w_dr = 1; w_dc = -1; end
    endcase
    if (r_side) begin
      w_dr = -w_dr;
      w_dc = -w_dc;
    end
    w_nr    = int'(r_pr) + w_dr;
    w_nc    = int'(r_pc) + w_dc;
    w_inb   = (w_nr >= 0) && (w_nr < N) &&
              (w_nc >= 0) && (w_nc < N);
    w_nidx  = IW'(w_nr * N + w_nc);
    w_match = w_inb && (r_board[w_nidx] == w_mark);
  end

  always_comb begin
    w_rd_idx = IW'(int'(bus.rd_row) * N +
                   int'(bus.rd_col));
    bus.rd_cell = 2'b00;
    if (int'(bus.rd_row) < N && int'(bus.rd_col) < N)
      bus.rd_cell = r_board[w_rd_idx];
  end

  assign bus.game_state = r_gs;
  assign bus.turn       = r_turn;
  assign bus.move_count = r_mc;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= S_INIT;
      for (int i = 0; i < NC; i++) r_board[i] <= 2'b00;
      r_s1    <= '1;
      r_s2    <= '1;
      r_s3    <= '1;
      r_rand  <= '0;
      r_probe <= '0;
      r_mode  <= 1'b0;
      r_turn  <= 1'b0;
      r_side  <= 1'b0;
      r_mc    <= '0;
      r_gs    <= 3'd0;
      r_lr    <= '0;
      r_lc    <= '0;
      r_pr    <= '0;
      r_pc    <= '0;
      r_dir   <= '0;
      r_step  <= '0;
      r_run   <= '0;
    end else begin
      r_s1   <= bus.btn;
      r_s2   <= r_s1;
      r_s3   <= r_s2;
      r_rand <= (int'(r_rand) == NC - 1) ? '0 : r_rand + 1'b1;
      if (bus.new_game) begin
        for (int i = 0; i < NC; i++) r_board[i] <= 2'b00;
        r_turn  <= 1'b0;
        r_mc    <= '0;
        r_gs    <= 3'd0;
        r_state <= S_INIT;
      end else begin
        unique case (r_state)
          S_INIT: begin
            r_mode  <= bus.vs_cpu;
            r_gs    <= 3'd1;
            r_state <= S_PLAY;
          end
          S_PLAY: begin
            if (w_any && r_board[w_sel] == 2'b00 &&
                !(r_mode && r_turn)) begin
              r_board[w_sel] <= w_mark;
              r_mc    <= r_mc + 7'd1;
              r_lr    <= w_sel_r;
              r_lc    <= w_sel_c;
              r_pr    <= w_sel_r;
              r_pc    <= w_sel_c;
              r_dir   <= '0;
              r_side  <= 1'b0;
              r_step  <= '0;
              r_run   <= '0;
              r_state <= S_CHECK;
            end
          end
          S_SEEK: begin
            if (r_board[r_probe] == 2'b00) begin
              r_board[r_probe] <= 2'b10;
              r_mc    <= r_mc + 7'd1;
              r_lr    <= w_prb_r;
              r_lc    <= w_prb_c;
              r_pr    <= w_prb_r;
              r_pc    <= w_prb_c;
              r_dir   <= '0;
              r_side  <= 1'b0;
              r_step  <= '0;
              r_run   <= '0;
              r_state <= S_CHECK;
            end else begin
              r_probe <= (int'(r_probe) == NC - 1) ?
                         '0 : r_probe + 1'b1;
            end
          end
          S_CHECK: begin
            if (w_match && int'(r_run) + 2 >= K) begin
              r_state <= r_turn ? S_WIN1 : S_WIN0;
              r_gs    <= r_turn ? 3'd3 : 3'd2;
            end else if (w_match &&
                         int'(r_step) + 1 < K - 1) begin
              r_run  <= r_run + 4'd1;
              r_step <= r_step + 4'd1;
              r_pr   <= 3'(w_nr);
              r_pc   <= 3'(w_nc);
            end else if (!r_side) begin
              // Flip to the minus side; run carries over
              r_side <= 1'b1;
              r_step <= '0;
              r_pr   <= r_lr;
              r_pc   <= r_lc;
              if (w_match) r_run <= r_run + 4'd1;
            end else if (r_dir != 2'd3) begin
              r_dir  <= r_dir + 2'd1;
              r_side <= 1'b0;
              r_step <= '0;
              r_run  <= '0;
              r_pr   <= r_lr;
              r_pc   <= r_lc;
            end else if (int'(r_mc) == NC) begin
              r_state <= S_DRAW;
              r_gs    <= 3'd4;
            end else begin
              r_turn <= ~r_turn;
              if (r_mode && !r_turn) begin
                r_probe <= r_rand;
                r_state <= S_SEEK;
              end else begin
                r_state <= S_PLAY;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule
